vector_group_regbank: RTL and testbench
=======================================

VECTOR_GROUP_REGBANK -- requirements
Module: vector_group_regbank

Interface
REQ-001 SHALL have parameter VLEN, default 64: vector register width in bits; legal values are multiples of 64.
REQ-002 SHALL have parameter VLENB, default VLEN/8: byte-enable width.
REQ-003 SHALL have parameter NREAD, default 3: read channels vs1, vs2, vs3, legal 2..3; vs3 is absent when NREAD=2.
REQ-004 SHALL have ports:
  clk  in  1  clock
  reset_n  in  1  reset, asynchronous, active-low
  req_valid  in  1  group read request
  req_ready  out  1  request accepted when req_valid and req_ready are both high
  req_lmul  in  2  group size: 0=1, 1=2, 2=4, 3=8 registers
  req_vs1/req_vs2/req_vs3  in  5 each  group base addresses
  rd_valid  out  1  read beat valid
  rd_ready  in  1  consumer accepts beat
  rd_idx  out  3  beat index within group
  rd_last  out  1  final beat of group
  rd_err  out  1  request rejected, misaligned
  vs1_data/vs2_data/vs3_data  out  VLEN each  beat data
  wr_en  in  VLENB  byte write enables
  wr_addr  in  5  destination register
  wr_data  in  VLEN  write data
  v0_mask  out  VLEN  live contents of v0

Function
REQ-005 SHALL hold 32 registers of VLEN bits; a write SHALL update only the bytes i with wr_en[i]=1, on the clock edge, independent of FSM state.
REQ-006 SHALL output v0_mask combinationally from register 0, reflecting a write one cycle after the write edge.
REQ-007 SHALL implement FSM IDLE -> BURST -> IDLE; req_ready=1 only in IDLE with no pending output beat.
REQ-008 On acceptance, SHALL latch the bases and N=2^req_lmul, and set beat counter k=0.
REQ-009 In BURST, SHALL present a registered beat: data = reg[base+k] for each channel, rd_idx=k, rd_last=(k==N-1); first beat valid the cycle after acceptance.
REQ-010 SHALL advance k only on rd_valid & rd_ready; while the beat is stalled, data and rd_idx SHALL hold stable except as permitted by REQ-011.
REQ-011 Write bypass: a write hitting the register of a presented, unaccepted beat SHALL merge the enabled bytes into the held beat on that edge.
REQ-012 On acceptance of a beat with rd_last=1, SHALL return to IDLE; req_ready SHALL rise the following cycle.
REQ-013 Any base with base mod N != 0 SHALL abort the request: a single beat with rd_valid=1, rd_err=1, rd_last=1, and all data zero, then return to IDLE; no register access.
REQ-014 A write and a read of the same register in the same cycle SHALL return the new bytes for enabled lanes (write-first).
REQ-015 Group addresses SHALL never wrap past 31; REQ-013 guarantees this.

Reset
REQ-016 On reset_n=0, SHALL asynchronously clear all registers, FSM to IDLE, k=0, and drive rd_valid=0, rd_err=0, rd_last=0, rd_idx=0, data=0, req_ready=0 during reset, then 1 in the first cycle after release.
REQ-017 A reset asserted mid-burst SHALL discard the burst with no further beats.

Structure
REQ-018 The lmul_e enum (LMUL1/2/4/8) and burst_state_e SHALL reside in RS5_pkg.
REQ-019 SHALL instantiate one sub-module, vector_reg_array: the 32xVLEN byte-enabled storage with NREAD asynchronous read ports; the FSM, counter, and bypass live in the top.

Verification
REQ-020 Write 0xFF..FF to v5 with wr_en=0x0F, then group-read vs1=5 with lmul=0 -> vs1_data=0x00000000FFFFFFFF, rd_last=1, rd_idx=0.
REQ-021 lmul=2 (N=4), vs1=8, vs2=12, with rd_ready always 1 -> 4 consecutive beats, idx 0..3, data v8..v11 and v12..v15, rd_last on beat 3, req_ready high 1 cycle later.
REQ-022 lmul=1, vs1=8, hold rd_ready=0 for 3 cycles on beat 0 while writing v8 byte 0 = 0xAB -> held beat shows byte 0 = 0xAB, idx stays 0.
REQ-023 lmul=3, vs1=4 -> one beat with rd_err=1, rd_last=1, data 0; no other beats.
REQ-024 Assert reset_n=0 at beat 2 of an lmul=3 burst -> rd_valid=0 immediately; all registers read 0 after release; v0_mask=0.
REQ-025 NREAD=2 build: vs3 absent; REQ-021 passes unchanged.

Source files
------------

// File: rtl/RS5_pkg.sv
// Shared types for the vector register bank: group-size encoding and burst FSM states.
package RS5_pkg;

    typedef enum logic [1:0] {
        LMUL1 = 2'd0,
        LMUL2 = 2'd1,
        LMUL4 = 2'd2,
        LMUL8 = 2'd3
    } lmul_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_e;

    localparam int NREGS = 32;

    // Low-address bits that must be zero for a group base to be aligned (N-1).
    function automatic logic [4:0] group_mask(input lmul_e lmul);
        case (lmul)
            LMUL1:   return 5'd0;
            LMUL2:   return 5'd1;
            LMUL4:   return 5'd3;
            default: return 5'd7;
        endcase
    endfunction

    // Beat index of the final beat in a group (N-1).
    function automatic logic [2:0] group_last(input lmul_e lmul);
        case (lmul)
            LMUL1:   return 3'd0;
            LMUL2:   return 3'd1;
            LMUL4:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/vector_reg_array.sv
// 32 x VLEN vector register storage: byte-enabled write port, NREAD asynchronous read
// ports, and a dedicated view of v0.
module vector_reg_array
    import RS5_pkg::*;
#(
    parameter int VLEN  = 64,
    parameter int VLENB = VLEN / 8,
    parameter int NREAD = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [VLENB-1:0]            wr_en,
    input  logic [4:0]                  wr_addr,
    input  logic [VLEN-1:0]             wr_data,
    input  logic [NREAD-1:0][4:0]       rd_addr,
    output logic [NREAD-1:0][VLEN-1:0]  rd_data,
    output logic [VLEN-1:0]             v0
);

    logic [VLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int b = 0; b < VLENB; b++) begin
                if (wr_en[b]) begin
                    regs[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        assign rd_data[gi] = regs[rd_addr[gi]];
    end

    assign v0 = regs[0];

endmodule

// File: rtl/vector_group_regbank.sv
// Vector register bank with register-group burst reads: one request streams N=2^lmul
// beats per read channel, with write bypass into a stalled beat.
module vector_group_regbank
    import RS5_pkg::*;
#(
    parameter int VLEN  = 64,
    parameter int VLENB = VLEN / 8,
    parameter int NREAD = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_lmul,
    input  logic [4:0]       req_vs1,
    input  logic [4:0]       req_vs2,
    input  logic [4:0]       req_vs3,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [2:0]       rd_idx,
    output logic             rd_last,
    output logic             rd_err,
    output logic [VLEN-1:0]  vs1_data,
    output logic [VLEN-1:0]  vs2_data,
    output logic [VLEN-1:0]  vs3_data,
    input  logic [VLENB-1:0] wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [VLEN-1:0]  wr_data,
    output logic [VLEN-1:0]  v0_mask
);

    burst_state_e               state_reg, state_next;
    lmul_e                      lmul_reg, lmul_sel;
    logic [2:0]                 k_reg, k_next;
    logic [NREAD-1:0][4:0]      base_reg, req_base, rd_addr;
    logic [NREAD-1:0][VLEN-1:0] arr_data, beat_reg, beat_next;
    logic                       valid_reg, valid_next;
    logic                       last_reg, last_next;
    logic                       err_reg, err_next;
    logic [VLEN-1:0]            wr_bitmask;
    logic                       accept, fire, burst_done, misaligned, load_beat;

    assign req_base[0] = req_vs1;
    assign req_base[1] = req_vs2;

    if (NREAD == 3) begin : g_vs3
        assign req_base[2] = req_vs3;
        assign vs3_data    = beat_reg[2];
    end else begin : g_no_vs3
        logic unused_vs3;
        assign unused_vs3 = ^req_vs3;
        assign vs3_data   = '0;
    end

    for (genvar gi = 0; gi < VLENB; gi++) begin : g_lane
        assign wr_bitmask[gi*8 +: 8] = {8{wr_en[gi]}};
    end

    vector_reg_array #(
        .VLEN  (VLEN),
        .VLENB (VLENB),
        .NREAD (NREAD)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (arr_data),
        .v0      (v0_mask)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = BURST;
            BURST:   if (burst_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready is gated by reset_n so it stays low while reset is held.
    always_comb begin
        req_ready  = (state_reg == IDLE) && !valid_reg && reset_n;
        accept     = req_valid && req_ready;
        fire       = valid_reg && rd_ready;
        burst_done = fire && last_reg;
    end

    always_comb begin
        misaligned = 1'b0;
        for (int c = 0; c < NREAD; c++) begin
            if ((req_base[c] & group_mask(lmul_e'(req_lmul))) != 5'd0) begin
                misaligned = 1'b1;
            end
        end
    end

    always_comb begin
        k_next = k_reg;
        if (accept || burst_done) begin
            k_next = 3'd0;
        end else if (fire) begin
            k_next = k_reg + 3'd1;
        end
    end

    // Read ports address the register that will sit in the beat after this edge.
    always_comb begin
        rd_addr = '0;
        for (int c = 0; c < NREAD; c++) begin
            rd_addr[c] = (state_reg == IDLE) ? req_base[c] : base_reg[c] + {2'b00, k_next};
        end
    end

    always_comb begin
        load_beat = (accept && !misaligned) ||
                    ((state_reg == BURST) && !err_reg && !burst_done);
        beat_next = '0;
        for (int c = 0; c < NREAD; c++) begin
            if (load_beat) begin
                if (wr_addr == rd_addr[c]) begin
                    beat_next[c] = (arr_data[c] & ~wr_bitmask) | (wr_data & wr_bitmask);
                end else begin
                    beat_next[c] = arr_data[c];
                end
            end
        end
    end

    always_comb begin
        lmul_sel   = accept ? lmul_e'(req_lmul) : lmul_reg;
        valid_next = accept ? 1'b1 : (burst_done ? 1'b0 : valid_reg);
        err_next   = accept ? misaligned : (burst_done ? 1'b0 : err_reg);
        last_next  = valid_next && (err_next || (k_next == group_last(lmul_sel)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_reg     <= '0;
            lmul_reg  <= LMUL1;
            base_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            err_reg   <= 1'b0;
            beat_reg  <= '0;
        end else begin
            k_reg     <= k_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
            err_reg   <= err_next;
            beat_reg  <= beat_next;
            if (accept) begin
                lmul_reg <= lmul_e'(req_lmul);
                base_reg <= req_base;
            end
        end
    end

    assign rd_valid = valid_reg;
    assign rd_last  = last_reg;
    assign rd_err   = err_reg;
    assign rd_idx   = k_reg;
    assign vs1_data = beat_reg[0];
    assign vs2_data = beat_reg[1];

endmodule

// File: tb/tb_vector_group_regbank.sv
// Bench for vector_group_regbank: a register-file/burst model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vector_group_regbank;

    localparam int VLEN  = 64;
    localparam int VLENB = 8;
    localparam int NREAD = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_lmul = '0;
    logic [4:0]       req_vs1 = '0, req_vs2 = '0, req_vs3 = '0;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [2:0]       rd_idx;
    logic             rd_last, rd_err;
    logic [VLEN-1:0]  vs1_data, vs2_data, vs3_data;
    logic [VLENB-1:0] wr_en = '0;
    logic [4:0]       wr_addr = '0;
    logic [VLEN-1:0]  wr_data = '0;
    logic [VLEN-1:0]  v0_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vector_group_regbank #(.VLEN(VLEN), .VLENB(VLENB), .NREAD(NREAD)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_lmul(req_lmul),
        .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vs3(req_vs3),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx),
        .rd_last(rd_last), .rd_err(rd_err),
        .vs1_data(vs1_data), .vs2_data(vs2_data), .vs3_data(vs3_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .v0_mask(v0_mask)
    );

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain register file plus "is a group being streamed, which beat is up".
    logic [VLEN-1:0] m_regs [32];
    logic            m_busy, m_err;
    int              m_base [3];
    int              m_n, m_k;

    always @(posedge clk or negedge reset_n) begin
        int n;
        if (!reset_n) begin
            for (int r = 0; r < 32; r++) m_regs[r] <= '0;
            m_busy <= 1'b0;
            m_err  <= 1'b0;
            m_n    <= 1;
            m_k    <= 0;
        end else begin
            if (m_busy && rd_ready) begin
                if (m_err || m_k == m_n - 1) m_busy <= 1'b0;
                else m_k <= m_k + 1;
            end else if (!m_busy && req_valid) begin
                n = 1 << req_lmul;
                m_n       <= n;
                m_base[0] <= int'(req_vs1);
                m_base[1] <= int'(req_vs2);
                m_base[2] <= int'(req_vs3);
                m_err  <= (int'(req_vs1) % n != 0) || (int'(req_vs2) % n != 0) || (int'(req_vs3) % n != 0);
                m_busy <= 1'b1;
                m_k    <= 0;
            end
            for (int b = 0; b < VLENB; b++)
                if (wr_en[b]) m_regs[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    // Beat data is the live register contents, so bypass and write-first fall out naturally.
    always @(negedge clk) begin
        logic [VLEN-1:0] e1, e2, e3;
        check("rd_valid", {63'd0, rd_valid}, {63'd0, m_busy});
        check("req_ready", {63'd0, req_ready}, {63'd0, reset_n && !m_busy});
        check("v0_mask", v0_mask, m_regs[0]);
        if (m_busy || !reset_n) begin
            e1 = '0; e2 = '0; e3 = '0;
            if (m_busy && !m_err) begin
                e1 = m_regs[m_base[0] + m_k];
                e2 = m_regs[m_base[1] + m_k];
                e3 = m_regs[m_base[2] + m_k];
            end
            check("rd_err", {63'd0, rd_err}, {63'd0, m_busy && m_err});
            check("rd_last", {63'd0, rd_last}, {63'd0, m_busy && (m_err || m_k == m_n - 1)});
            check("rd_idx", {61'd0, rd_idx}, (m_busy && !m_err) ? VLEN'(m_k) : '0);
            check("vs1_data", vs1_data, e1);
            check("vs2_data", vs2_data, e2);
            check("vs3_data", vs3_data, e3);
        end
    end

    function automatic logic [VLEN-1:0] pat(input int i);
        return {8'(i), 8'hA5, 16'h1234, 8'(i) ^ 8'h5A, 8'(3 * i), 8'hC3, 8'(i + 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input logic [VLEN-1:0] d, input logic [VLENB-1:0] en);
        wr_addr = 5'(a); wr_data = d; wr_en = en;
        tick();
        wr_en = '0;
    endtask

    task automatic request(input int lmul, input int a1, input int a2, input int a3);
        req_lmul = 2'(lmul); req_vs1 = 5'(a1); req_vs2 = 5'(a2); req_vs3 = 5'(a3);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [VLEN-1:0] tmp;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {63'd0, req_ready}, 64'd1);
        tick();

        // Partial write to an empty register, then a single-register group read.
        write_reg(5, '1, 8'h0F);
        rd_ready = 1'b1;
        request(0, 5, 0, 0);
        @(negedge clk);
        check("r20_data", vs1_data, 64'h00000000FFFFFFFF);
        check("r20_last", {63'd0, rd_last}, 64'd1);
        check("r20_idx", {61'd0, rd_idx}, 64'd0);
        tick();

        for (int i = 0; i < 32; i++) if (i != 5) write_reg(i, pat(i), 8'hFF);

        // Four-beat groups streamed back to back.
        request(2, 8, 12, 16);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            $display("beat idx=%0d vs1=%h vs2=%h last=%0b", rd_idx, vs1_data, vs2_data, rd_last);
            check("r21_idx", {61'd0, rd_idx}, 64'(j));
            check("r21_vs1", vs1_data, pat(8 + j));
            check("r21_vs2", vs2_data, pat(12 + j));
            check("r21_last", {63'd0, rd_last}, {63'd0, j == 3});
        end
        @(negedge clk);
        check("r21_ready", {63'd0, req_ready}, 64'd1);
        check("r21_done", {63'd0, rd_valid}, 64'd0);

        // Stalled beat receives a byte write to its own register.
        rd_ready = 1'b0;
        request(1, 8, 10, 12);
        wr_addr = 5'd8; wr_data = 64'hAB; wr_en = 8'h01;
        tick();
        wr_en = '0;
        tick();
        tick();
        @(negedge clk);
        tmp = pat(8);
        check("r22_byte0", {56'd0, vs1_data[7:0]}, 64'hAB);
        check("r22_upper", {8'd0, vs1_data[63:8]}, {8'd0, tmp[63:8]});
        check("r22_idx", {61'd0, rd_idx}, 64'd0);
        rd_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("r22_done", {63'd0, rd_valid}, 64'd0);

        // Misaligned base aborts with one error beat.
        request(3, 4, 8, 16);
        @(negedge clk);
        check("r23_err", {63'd0, rd_err}, 64'd1);
        check("r23_last", {63'd0, rd_last}, 64'd1);
        check("r23_data", vs1_data | vs2_data | vs3_data, 64'd0);
        @(negedge clk);
        check("r23_single", {63'd0, rd_valid}, 64'd0);
        tick();

        // Write on the acceptance edge lands in the first beat (write-first).
        wr_addr = 5'd20; wr_data = 64'h0123456789ABCDEF; wr_en = 8'hF0;
        request(0, 20, 21, 22);
        wr_en = '0;
        @(negedge clk);
        tmp = pat(20);
        check("wfirst", vs1_data, {32'h01234567, tmp[31:0]});
        tick();

        // Random stalls and writes into the active group; model checks every cycle.
        request(2, 16, 20, 24);
        for (int c = 0; c < 30; c++) begin
            rd_ready = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(16, 27));
            wr_data  = {$urandom, $urandom};
            wr_en    = 8'($urandom);
            tick();
        end
        wr_en = '0;
        rd_ready = 1'b1;
        for (int t = 0; t < 20 && rd_valid; t++) tick();
        check("drain_timeout", {63'd0, rd_valid}, 64'd0);
        tick();

        // Reset in the middle of an eight-beat burst.
        request(3, 8, 16, 24);
        tick();
        tick();
        @(negedge clk);
        check("r24_idx", {61'd0, rd_idx}, 64'd2);
        #2 reset_n = 1'b0;
        #1;
        check("r24_valid", {63'd0, rd_valid}, 64'd0);
        check("r24_ready", {63'd0, req_ready}, 64'd0);
        check("r24_data", vs1_data, 64'd0);
        check("r24_v0", v0_mask, 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        request(3, 0, 8, 16);
        req_vs3 = 5'd24;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("r24_cleared", vs1_data | vs2_data, 64'd0);
        end
        @(negedge clk);
        check("r24_end", {63'd0, rd_valid}, 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
